// File: rtl/extension_pipe_if.sv
// Operand/result handshake bundle for extension_pipe.
// The slave modport is the pipe itself; master is the producer/consumer side.
interface extension_pipe_if #(
  parameter int N     = 4,
  parameter int M     = 6,
  parameter int DEPTH = 2
);
  logic                       in_valid;
  logic                       in_ready;
  logic [N-1:0]               in_data;
  logic [1:0]                 mode;
  logic                       out_valid;
  logic                       out_ready;
  logic [M-1:0]               out_data;
  logic [$clog2(DEPTH):0]     count;
  logic                       err;

  modport slave (
    input  in_valid, in_data, mode, out_ready,
    output in_ready, out_valid, out_data, count, err
  );

  modport master (
    output in_valid, in_data, mode, out_ready,
    input  in_ready, out_valid, out_data, count, err
  );
endinterface

// File: rtl/extension_pipe.sv
// Sign/zero/negate extension of an N-bit operand to M bits, results queued in
// a DEPTH-entry FIFO with one cycle of latency and a sticky illegal-mode flag.
module extension_pipe #(
  parameter int N     = 4,
  parameter int M     = 6,
  parameter int DEPTH = 2
) (
  input  logic              clk,
  input  logic              reset,
  extension_pipe_if.slave   bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  localparam logic [1:0] MODE_SEXT = 2'b00;
  localparam logic [1:0] MODE_ZEXT = 2'b01;
  localparam logic [1:0] MODE_NEG  = 2'b10;

  logic [M-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] cnt;
  logic          err_q;
  logic [M-1:0]  sext, result;
  logic          push, pop, illegal;

  assign bus.in_ready  = (cnt < DEPTH_C);
  assign bus.out_valid = (cnt != '0);
  assign bus.out_data  = bus.out_valid ? mem[rd_ptr] : '0;
  assign bus.count     = cnt;
  assign bus.err       = err_q;

  // Pop is qualified by out_valid, so a push into an empty buffer never pops.
  assign push = bus.in_valid && bus.in_ready;
  assign pop  = bus.out_valid && bus.out_ready;

  assign sext = {{(M-N){bus.in_data[N-1]}}, bus.in_data};

  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    result  = '0;
    illegal = 1'b0;
    case (bus.mode)
      MODE_SEXT: result = sext;
      MODE_ZEXT: result = {{(M-N){1'b0}}, bus.in_data};
      MODE_NEG:  result = (~sext) + M'(1);
      default:   illegal = 1'b1;
    endcase
  end

  // NOTE: storage has no reset; entries are unobservable while cnt is 0, and
  // leaving them unreset lets the array map onto plain RAM cells.
  always_ff @(posedge clk) begin
    if (!reset && push) mem[wr_ptr] <= result;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
      err_q  <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   cnt <= cnt + CW'(1);
        2'b01:   cnt <= cnt - CW'(1);
        default: cnt <= cnt;
      endcase
      if (push && illegal) err_q <= 1'b1;
    end
  end
endmodule

// File: tb/tb_extension_pipe.sv
// Scoreboard bench for extension_pipe (N=4, M=6, DEPTH=2).
module tb_extension_pipe;
  localparam int N     = 4;
  localparam int M     = 6;
  localparam int DEPTH = 2;

  logic clk;
  logic reset;
  int   errors = 0;
  int   checks = 0;

  logic [M-1:0] sb[$];
  logic         err_m;

  extension_pipe_if #(.N(N), .M(M), .DEPTH(DEPTH)) bus ();

  extension_pipe #(.N(N), .M(M), .DEPTH(DEPTH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [M-1:0] model(input logic [N-1:0] d, input logic [1:0] md);
    int sv;
    logic [M-1:0] r;
    sv = d[N-1] ? int'(d) - (1 << N) : int'(d);
    case (md)
      2'b00:   r = M'(sv);
      2'b01:   r = M'(int'(d));
      2'b10:   r = M'(-sv);
      default: r = '0;
    endcase
    return r;
  endfunction

  // One clock: check registered outputs against the model, drive inputs,
  // advance the model across the edge, then settle 1 time unit after it.
  task automatic step(input logic v, input logic [N-1:0] d, input logic [1:0] md,
                      input logic ordy, input logic rst);
    logic [M-1:0] exp_data;
    logic         do_push, do_pop;
    bus.in_valid  = v;
    bus.in_data   = d;
    bus.mode      = md;
    bus.out_ready = ordy;
    reset         = rst;
    exp_data = (sb.size() != 0) ? sb[0] : '0;
    checks += 4;
    if (bus.in_ready !== (sb.size() < DEPTH)) begin
      errors++; $display("FAIL step_in_ready got=%b want=%b", bus.in_ready, sb.size() < DEPTH);
    end
    if (bus.out_valid !== (sb.size() != 0)) begin
      errors++; $display("FAIL step_out_valid got=%b want=%b", bus.out_valid, sb.size() != 0);
    end
    if (bus.count !== ($clog2(DEPTH)+1)'(sb.size())) begin
      errors++; $display("FAIL step_count got=%0d want=%0d", bus.count, sb.size());
    end
    if (bus.out_data !== exp_data) begin
      errors++; $display("FAIL step_out_data got=%b want=%b", bus.out_data, exp_data);
    end
    checks++;
    if (bus.err !== err_m) begin
      errors++; $display("FAIL step_err got=%b want=%b", bus.err, err_m);
    end
    do_push = v && (sb.size() < DEPTH);
    do_pop  = ordy && (sb.size() != 0);
    @(posedge clk);
    if (rst) begin
      sb.delete();
      err_m = 1'b0;
    end else begin
      if (do_pop)  void'(sb.pop_front());
      if (do_push) sb.push_back(model(d, md));
      if (do_push && md == 2'b11) err_m = 1'b1;
    end
    #1;
  endtask

  task automatic drain();
    for (int i = 0; i < DEPTH + 1; i++) step(1'b0, '0, 2'b00, 1'b1, 1'b0);
  endtask

  task automatic test_reset();
    step(1'b0, '0, 2'b00, 1'b0, 1'b1);
    step(1'b0, '0, 2'b00, 1'b0, 1'b1);
    checks += 5;
    if (bus.count !== '0)      begin errors++; $display("FAIL reset_count got=%0d want=0", bus.count); end
    if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%b want=0", bus.out_valid); end
    if (bus.in_ready !== 1'b1)  begin errors++; $display("FAIL reset_in_ready got=%b want=1", bus.in_ready); end
    if (bus.out_data !== '0)   begin errors++; $display("FAIL reset_out_data got=%b want=0", bus.out_data); end
    if (bus.err !== 1'b0)       begin errors++; $display("FAIL reset_err got=%b want=0", bus.err); end
  endtask

  task automatic test_extension();
    step(1'b1, 4'b1010, 2'b00, 1'b0, 1'b0);
    checks += 2;
    if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL sext_valid got=%b want=1", bus.out_valid); end
    if (bus.out_data !== 6'b111010) begin errors++; $display("FAIL sext_data got=%b want=111010", bus.out_data); end
    step(1'b0, '0, 2'b00, 1'b1, 1'b0);
    step(1'b1, 4'b1010, 2'b01, 1'b0, 1'b0);
    checks++;
    if (bus.out_data !== 6'b001010) begin errors++; $display("FAIL zext_data got=%b want=001010", bus.out_data); end
    step(1'b0, '0, 2'b00, 1'b1, 1'b0);
  endtask

  task automatic test_negate();
    logic [N-1:0] din [3] = '{4'b0011, 4'b1000, 4'b0000};
    logic [M-1:0] want[3] = '{6'b111101, 6'b001000, 6'b000000};
    for (int i = 0; i < 3; i++) begin
      step(1'b1, din[i], 2'b10, 1'b0, 1'b0);
      checks++;
      if (bus.out_data !== want[i]) begin
        errors++; $display("FAIL neg_%0d got=%b want=%b", i, bus.out_data, want[i]);
      end
      step(1'b0, '0, 2'b00, 1'b1, 1'b0);
    end
  endtask

  task automatic test_full();
    step(1'b1, 4'd1, 2'b01, 1'b0, 1'b0);
    step(1'b1, 4'd2, 2'b01, 1'b0, 1'b0);
    checks += 2;
    if (bus.count !== 2'd2)    begin errors++; $display("FAIL full_count got=%0d want=2", bus.count); end
    if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL full_in_ready got=%b want=0", bus.in_ready); end
    step(1'b1, 4'd3, 2'b01, 1'b0, 1'b0);
    checks++;
    if (bus.out_data !== 6'd1) begin errors++; $display("FAIL full_head1 got=%0d want=1", bus.out_data); end
    // Pop while full with a push offered: the push must not pass through.
    step(1'b1, 4'd4, 2'b01, 1'b1, 1'b0);
    checks += 3;
    if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL full_ready_after_pop got=%b want=1", bus.in_ready); end
    if (bus.count !== 2'd1)    begin errors++; $display("FAIL full_count_after_pop got=%0d want=1", bus.count); end
    if (bus.out_data !== 6'd2) begin errors++; $display("FAIL full_head2 got=%0d want=2", bus.out_data); end
    drain();
  endtask

  task automatic test_back_to_back();
    step(1'b1, 4'd5, 2'b01, 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) step(1'b1, 4'(i), 2'b01, 1'b1, 1'b0);
    checks += 2;
    if (bus.count !== 2'd1)     begin errors++; $display("FAIL b2b_count got=%0d want=1", bus.count); end
    if (bus.out_data !== 6'd3)  begin errors++; $display("FAIL b2b_last got=%0d want=3", bus.out_data); end
    drain();
  endtask

  task automatic test_err();
    step(1'b1, 4'b1001, 2'b11, 1'b0, 1'b0);
    checks += 2;
    if (bus.out_data !== '0) begin errors++; $display("FAIL err_data got=%b want=0", bus.out_data); end
    if (bus.err !== 1'b1)    begin errors++; $display("FAIL err_set got=%b want=1", bus.err); end
    step(1'b1, 4'b0010, 2'b00, 1'b1, 1'b0);
    step(1'b0, 4'b0000, 2'b11, 1'b1, 1'b0);
    checks++;
    if (bus.err !== 1'b1) begin errors++; $display("FAIL err_sticky got=%b want=1", bus.err); end
    step(1'b0, '0, 2'b00, 1'b0, 1'b1);
    checks++;
    if (bus.err !== 1'b0) begin errors++; $display("FAIL err_clear got=%b want=0", bus.err); end
  endtask

  task automatic test_reset_midstream();
    step(1'b1, 4'd6, 2'b01, 1'b0, 1'b0);
    step(1'b1, 4'd7, 2'b01, 1'b0, 1'b0);
    step(1'b1, 4'd8, 2'b01, 1'b1, 1'b1);
    checks += 4;
    if (bus.count !== '0)       begin errors++; $display("FAIL mid_count got=%0d want=0", bus.count); end
    if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL mid_out_valid got=%b want=0", bus.out_valid); end
    if (bus.in_ready !== 1'b1)  begin errors++; $display("FAIL mid_in_ready got=%b want=1", bus.in_ready); end
    if (bus.out_data !== '0)    begin errors++; $display("FAIL mid_out_data got=%b want=0", bus.out_data); end
    step(1'b0, '0, 2'b00, 1'b0, 1'b0);
  endtask

  task automatic test_random();
    for (int i = 0; i < 200; i++)
      step(1'($urandom_range(0, 1)), 4'($urandom), 2'($urandom), 1'($urandom_range(0, 1)), 1'b0);
    drain();
  endtask

  initial begin
    err_m         = 1'b0;
    reset         = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.mode      = 2'b00;
    bus.out_ready = 1'b0;
    @(posedge clk);
    #1;
    test_reset();
    test_extension();
    test_negate();
    test_full();
    test_back_to_back();
    test_err();
    test_reset_midstream();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
